// File: rtl/uart_fifo_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_bridge_if
// Brief    : Host-side and UART-side signal bundle for uart_fifo_bridge.
// Revision : 1.0
// ============================================================================
interface uart_fifo_bridge_if #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
);
    localparam int c_TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int c_RX_CW = $clog2(RX_DEPTH) + 1;

    logic                tx_wr_i;
    logic [7:0]          tx_data_i;
    logic                tx_full_o;
    logic [c_TX_CW-1:0]  tx_count_o;
    logic                rx_rd_i;
    logic [7:0]          rx_data_o;
    logic                rx_empty_o;
    logic [c_RX_CW-1:0]  rx_count_o;
    logic                overrun_o;
    logic                ovr_clr_i;
    logic                uart_wr_o;
    logic [7:0]          uart_tx_data_o;
    logic                uart_busy_i;
    logic                uart_rd_o;
    logic [7:0]          uart_rx_data_i;
    logic                uart_valid_i;

    modport slave (
        input  tx_wr_i, tx_data_i, rx_rd_i, ovr_clr_i,
               uart_busy_i, uart_rx_data_i, uart_valid_i,
        output tx_full_o, tx_count_o, rx_data_o, rx_empty_o, rx_count_o,
               overrun_o, uart_wr_o, uart_tx_data_o, uart_rd_o
    );

    modport master (
        output tx_wr_i, tx_data_i, rx_rd_i, ovr_clr_i,
               uart_busy_i, uart_rx_data_i, uart_valid_i,
        input  tx_full_o, tx_count_o, rx_data_o, rx_empty_o, rx_count_o,
               overrun_o, uart_wr_o, uart_tx_data_o, uart_rd_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_bridge
// Brief    : TX/RX byte FIFOs between the system bus and the uart core.
// Revision : 1.0
// ============================================================================
module uart_fifo_bridge #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  wire                 clk,
    input  wire                 reset_ni,
    uart_fifo_bridge_if.slave   bus
);
    localparam int c_TX_AW = $clog2(TX_DEPTH);
    localparam int c_RX_AW = $clog2(RX_DEPTH);
    localparam int c_TX_CW = c_TX_AW + 1;
    localparam int c_RX_CW = c_RX_AW + 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ISSUE  = 2'd1;
    localparam logic [1:0] c_SETTLE = 2'd2;

    logic [7:0]          r_tx_mem [TX_DEPTH];
    logic [c_TX_AW-1:0]  r_tx_wptr;
    logic [c_TX_AW-1:0]  r_tx_rptr;
    logic [c_TX_CW-1:0]  r_tx_count;
    logic [7:0]          r_rx_mem [RX_DEPTH];
    logic [c_RX_AW-1:0]  r_rx_wptr;
    logic [c_RX_AW-1:0]  r_rx_rptr;
    logic [c_RX_CW-1:0]  r_rx_count;
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_uart_wr;
    logic [7:0]          r_uart_tx_data;
    logic                r_uart_rd;
    logic                r_overrun;

    logic w_tx_full, w_tx_nempty, w_tx_push, w_tx_pop;
    logic w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_rx_trig;

    assign w_tx_full   = (r_tx_count == c_TX_CW'(TX_DEPTH));
    assign w_tx_nempty = (r_tx_count != '0);
    // Fullness is judged before any same-cycle drain, so a push at full is always dropped
    assign w_tx_push   = bus.tx_wr_i && !w_tx_full;

    assign w_rx_full   = (r_rx_count == c_RX_CW'(RX_DEPTH));
    assign w_rx_empty  = (r_rx_count == '0);
    assign w_rx_trig   = bus.uart_valid_i && !r_uart_rd;
    assign w_rx_push   = w_rx_trig && !w_rx_full;
    assign w_rx_pop    = bus.rx_rd_i && !w_rx_empty;

    // ---------------- TX drain FSM ----------------
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) r_state <= c_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_tx_nempty && !bus.uart_busy_i) w_state_nxt = c_ISSUE;
            c_ISSUE:  w_state_nxt = c_SETTLE;
            c_SETTLE: w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_tx_pop = (r_state == c_IDLE) && w_tx_nempty && !bus.uart_busy_i;
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_uart_wr      <= 1'b0;
            r_uart_tx_data <= 8'h00;
        end else begin
            r_uart_wr <= w_tx_pop;
            if (w_tx_pop) r_uart_tx_data <= r_tx_mem[r_tx_rptr];
        end
    end

    // ---------------- TX FIFO ----------------
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= bus.tx_data_i;
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + c_TX_CW'(1);
                2'b01:   r_tx_count <= r_tx_count - c_TX_CW'(1);
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    // ---------------- RX capture and FIFO ----------------
    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= bus.uart_rx_data_i;
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
            r_uart_rd  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_uart_rd <= w_rx_trig;
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + c_RX_CW'(1);
                2'b01:   r_rx_count <= r_rx_count - c_RX_CW'(1);
                default: r_rx_count <= r_rx_count;
            endcase
            // A new overrun takes priority over a simultaneous clear
            if (w_rx_trig && w_rx_full) r_overrun <= 1'b1;
            else if (bus.ovr_clr_i)     r_overrun <= 1'b0;
        end
    end

    assign bus.tx_full_o      = w_tx_full;
    assign bus.tx_count_o     = r_tx_count;
    assign bus.rx_data_o      = r_rx_mem[r_rx_rptr];
    assign bus.rx_empty_o     = w_rx_empty;
    assign bus.rx_count_o     = r_rx_count;
    assign bus.overrun_o      = r_overrun;
    assign bus.uart_wr_o      = r_uart_wr;
    assign bus.uart_tx_data_o = r_uart_tx_data;
    assign bus.uart_rd_o      = r_uart_rd;
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_bridge
// Brief    : Directed self-checking bench for uart_fifo_bridge.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_fifo_bridge;
    localparam int TXD = 16;
    localparam int RXD = 16;

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    always #5 clk = ~clk;

    uart_fifo_bridge_if #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) bus ();
    uart_fifo_bridge #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk      (clk),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queues for both FIFOs, a minimum issue spacing of three edges
    byte unsigned txq[$];
    byte unsigned rxq[$];
    int           since = 3;
    bit           m_wr = 1'b0, m_rd = 1'b0, m_ovr = 1'b0;
    logic [7:0]   m_txd = 8'h00;

    always @(posedge clk or negedge reset_ni) begin
        bit issue, txfull, trig, rxfull, rxpop;
        if (!reset_ni) begin
            txq.delete(); rxq.delete();
            since = 3; m_wr = 1'b0; m_rd = 1'b0; m_ovr = 1'b0; m_txd = 8'h00;
        end else begin
            if (since < 3) since++;
            issue  = (txq.size() > 0) && !bus.uart_busy_i && (since >= 3);
            txfull = (txq.size() == TXD);
            m_wr   = issue;
            if (issue) begin
                m_txd = txq.pop_front();
                since = 0;
            end
            if (bus.tx_wr_i && !txfull) txq.push_back(bus.tx_data_i);

            trig   = bus.uart_valid_i && !m_rd;
            rxfull = (rxq.size() == RXD);
            rxpop  = bus.rx_rd_i && (rxq.size() > 0);
            if (rxpop) void'(rxq.pop_front());
            if (trig && !rxfull) rxq.push_back(bus.uart_rx_data_i);
            if (trig && rxfull)  m_ovr = 1'b1;
            else if (bus.ovr_clr_i) m_ovr = 1'b0;
            m_rd = trig;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("uart_wr", bus.uart_wr_o, m_wr);
            check("uart_tx_data", bus.uart_tx_data_o, m_txd);
            check("uart_rd", bus.uart_rd_o, m_rd);
            check("overrun", bus.overrun_o, m_ovr);
            check("tx_count", bus.tx_count_o, txq.size());
            check("tx_full", bus.tx_full_o, txq.size() == TXD);
            check("rx_count", bus.rx_count_o, rxq.size());
            check("rx_empty", bus.rx_empty_o, rxq.size() == 0);
            if (rxq.size() > 0) check("rx_data", bus.rx_data_o, rxq[0]);
        end
    end

    // UART busy behaviour: busy for 20 cycles starting one cycle after each sampled write
    bit auto_busy = 1'b0, man_busy = 1'b0, wr_prev = 1'b0;
    int busy_cnt = 0;
    initial begin
        bus.uart_busy_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (busy_cnt > 0) busy_cnt--;
            if (auto_busy && wr_prev) busy_cnt = 20;
            wr_prev = bus.uart_wr_o;
            bus.uart_busy_i = man_busy || (busy_cnt > 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_deliver(input logic [7:0] d, input bit clr, input bit pop, output int pulses);
        int guard;
        pulses = 0;
        bus.uart_valid_i = 1'b1; bus.uart_rx_data_i = d;
        bus.ovr_clr_i = clr; bus.rx_rd_i = pop;
        tick();
        bus.ovr_clr_i = 1'b0; bus.rx_rd_i = 1'b0;
        guard = 0;
        while (bus.uart_rd_o !== 1'b1 && guard < 8) begin
            tick();
            guard++;
        end
        if (guard >= 8) check("rx_ack_timeout", 0, 1);
        pulses = 1;
        tick();
        if (bus.uart_rd_o === 1'b1) pulses++;
        bus.uart_valid_i = 1'b0;
        tick();
        if (bus.uart_rd_o === 1'b1) pulses++;
    endtask

    task automatic pop_one();
        bus.rx_rd_i = 1'b1;
        tick();
        bus.rx_rd_i = 1'b0;
    endtask

    initial begin
        int p, npulse, bad, prev;
        logic [7:0] pdata[$];
        int cseq[$];
        logic [7:0] last;

        bus.tx_wr_i = 1'b1; bus.tx_data_i = 8'h99;
        bus.rx_rd_i = 1'b0; bus.ovr_clr_i = 1'b0;
        bus.uart_rx_data_i = 8'h00; bus.uart_valid_i = 1'b0;
        repeat (3) tick();

        // Reset state while a write is being attempted
        check("rst_uart_wr", bus.uart_wr_o, 0);
        check("rst_uart_tx_data", bus.uart_tx_data_o, 0);
        check("rst_uart_rd", bus.uart_rd_o, 0);
        check("rst_overrun", bus.overrun_o, 0);
        check("rst_tx_full", bus.tx_full_o, 0);
        check("rst_tx_count", bus.tx_count_o, 0);
        check("rst_rx_empty", bus.rx_empty_o, 1);
        check("rst_rx_count", bus.rx_count_o, 0);

        reset_ni = 1'b1; bus.tx_wr_i = 1'b0;
        check_en = 1'b1;
        tick();

        // Single byte latency: pulse two edges after the push, one cycle wide
        bus.tx_wr_i = 1'b1; bus.tx_data_i = 8'h55;
        tick();
        bus.tx_wr_i = 1'b0;
        check("lat_wr_early", bus.uart_wr_o, 0);
        tick();
        check("lat_wr", bus.uart_wr_o, 1);
        check("lat_data", bus.uart_tx_data_o, 8'h55);
        tick();
        check("lat_wr_width", bus.uart_wr_o, 0);
        repeat (3) tick();

        // TX burst with busy-paced drain
        auto_busy = 1'b1; man_busy = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            bus.tx_wr_i = 1'b1; bus.tx_data_i = 8'(8'h41 + i);
            tick();
        end
        bus.tx_wr_i = 1'b0;
        check("burst_count3", bus.tx_count_o, 3);
        man_busy = 1'b0;
        prev = 3;
        for (int c = 0; c < 120; c++) begin
            tick();
            if (bus.uart_wr_o === 1'b1) pdata.push_back(bus.uart_tx_data_o);
            if (int'(bus.tx_count_o) != prev) begin
                prev = int'(bus.tx_count_o);
                cseq.push_back(prev);
            end
        end
        check("burst_npulse", pdata.size(), 3);
        for (int i = 0; i < 3; i++)
            check("burst_data", (pdata.size() > i) ? pdata[i] : 8'hxx, 8'(8'h41 + i));
        check("burst_cseq_len", cseq.size(), 3);
        for (int i = 0; i < 3; i++)
            check("burst_cseq", (cseq.size() > i) ? cseq[i] : -1, 2 - i);

        // TX overflow: last two bytes must be dropped
        man_busy = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < TXD + 2; i++) begin
            bus.tx_wr_i = 1'b1; bus.tx_data_i = 8'(8'h60 + i);
            tick();
        end
        bus.tx_wr_i = 1'b0;
        check("full_flag", bus.tx_full_o, 1);
        check("full_count", bus.tx_count_o, TXD);
        man_busy = 1'b0;
        npulse = 0; bad = 0; last = 8'h00;
        for (int c = 0; c < 500; c++) begin
            tick();
            if (bus.uart_wr_o === 1'b1) begin
                npulse++;
                last = bus.uart_tx_data_o;
                if (bus.uart_tx_data_o >= 8'h70) bad++;
            end
        end
        check("full_npulse", npulse, TXD);
        check("full_last", last, 8'h6F);
        check("full_dropped", bad, 0);
        auto_busy = 1'b0;
        repeat (25) tick();

        // RX capture with valid held through the acknowledge cycle
        rx_deliver(8'hA5, 1'b0, 1'b0, p);
        check("cap_rd_pulses", p, 1);
        check("cap_count", bus.rx_count_o, 1);
        check("cap_data", bus.rx_data_o, 8'hA5);
        pop_one();
        check("cap_empty", bus.rx_empty_o, 1);
        pop_one();
        check("cap_empty_pop", bus.rx_count_o, 0);

        // RX overrun
        for (int i = 0; i <= RXD; i++) begin
            rx_deliver(8'(i), 1'b0, 1'b0, p);
            check("ovr_rd_pulses", p, 1);
        end
        check("ovr_flag", bus.overrun_o, 1);
        check("ovr_count", bus.rx_count_o, RXD);
        rx_deliver(8'h11, 1'b1, 1'b0, p);
        check("ovr_set_beats_clr", bus.overrun_o, 1);
        bus.ovr_clr_i = 1'b1;
        tick();
        bus.ovr_clr_i = 1'b0;
        check("ovr_cleared", bus.overrun_o, 0);
        for (int i = 0; i < RXD; i++) begin
            check("ovr_drain", bus.rx_data_o, 8'(i));
            pop_one();
        end
        check("ovr_drained", bus.rx_empty_o, 1);

        // Simultaneous RX push and pop at count 5
        for (int i = 0; i < 5; i++) rx_deliver(8'(8'h20 + i), 1'b0, 1'b0, p);
        check("sim_count5", bus.rx_count_o, 5);
        rx_deliver(8'h25, 1'b0, 1'b1, p);
        check("sim_count_kept", bus.rx_count_o, 5);
        for (int i = 0; i < 5; i++) begin
            check("sim_order", bus.rx_data_o, 8'(8'h21 + i));
            pop_one();
        end

        // Reset while the TX FSM is issuing
        rx_deliver(8'h33, 1'b0, 1'b0, p);
        bus.tx_wr_i = 1'b1; bus.tx_data_i = 8'h77;
        tick();
        bus.tx_wr_i = 1'b0;
        tick();
        check("issue_wr", bus.uart_wr_o, 1);
        check("issue_data", bus.uart_tx_data_o, 8'h77);
        reset_ni = 1'b0;
        #1;
        check("arst_wr", bus.uart_wr_o, 0);
        check("arst_data", bus.uart_tx_data_o, 0);
        check("arst_rx_empty", bus.rx_empty_o, 1);
        tick();
        reset_ni = 1'b1;
        repeat (4) tick();

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_fifo_bridge.md
# uart_fifo_bridge

Buffering stage between the system bus and the `uart` core. It accepts transmit bytes into a TX FIFO and drains them into `uart` one byte at a time, respecting its `busy_o`. It also empties `uart`'s single-byte receive register into an RX FIFO, acknowledging each byte with `rd_i`. Byte loss is therefore limited to explicit, flagged RX overrun.

## Interface

Parameters:
- `TX_DEPTH`, 16: TX FIFO entries; power of two, ≥ 2.
- `RX_DEPTH`, 16: RX FIFO entries; power of two, ≥ 2.

Ports:
- `clk` in, 1: single clock, shared with `uart`.
- `reset_ni` in, 1: asynchronous, active-low reset.
- `tx_wr_i` in, 1: push `tx_data_i` into the TX FIFO.
- `tx_data_i` in, 8: byte to send.
- `tx_full_o` out, 1: TX FIFO full.
- `tx_count_o` out, $clog2(TX_DEPTH)+1: TX FIFO occupancy.
- `rx_rd_i` in, 1: pop the RX FIFO head.
- `rx_data_o` out, 8: RX FIFO head, show-ahead.
- `rx_empty_o` out, 1: RX FIFO empty.
- `rx_count_o` out, $clog2(RX_DEPTH)+1: RX FIFO occupancy.
- `overrun_o` out, 1: sticky RX overrun flag.
- `ovr_clr_i` in, 1: clear `overrun_o`.
- `uart_wr_o` out, 1: to `uart.wr_i`; registered.
- `uart_tx_data_o` out, 8: to `uart.tx_data_i`; registered.
- `uart_busy_i` in, 1: from `uart.busy_o`.
- `uart_rd_o` out, 1: to `uart.rd_i`; registered.
- `uart_rx_data_i` in, 8: from `uart.rx_data_o`.
- `uart_valid_i` in, 1: from `uart.valid_o`.

## Operation

- **Reset values:** `uart_wr_o`=0, `uart_tx_data_o`=0, `uart_rd_o`=0, `overrun_o`=0. Both FIFOs are empty: `tx_full_o`=0, counts=0, `rx_empty_o`=1, `rx_data_o` is don't-care. The TX FSM is in IDLE.
- **FIFOs:**
  - Circular buffers with read/write pointers that wrap modulo DEPTH.
  - Occupancy counter is one bit wider than the pointers.
  - A push and a pop in the same cycle leaves the count unchanged.
- **TX push:** `tx_wr_i` while `tx_full_o` is 1 is dropped. This holds even if the drain pops in the same cycle.
- **RX pop:** `rx_rd_i` while `rx_empty_o` is 1 is ignored.
- **TX drain FSM:**
  - IDLE: if the TX FIFO is non-empty and `uart_busy_i`=0, then on the clock edge:
    - `uart_wr_o`<=1
    - `uart_tx_data_o`<=head
    - pop the TX FIFO
    - go to ISSUE.
  - ISSUE: `uart_wr_o`<=0; go to SETTLE. `uart` samples the write on this edge.
  - SETTLE: go to IDLE. This state unconditionally ignores `uart_busy_i` for one cycle, because `busy_o` rises only the cycle after `wr_i` is sampled.
  - `uart_busy_i`=1 at startup (the UART dummy frame) simply holds the FSM in IDLE.
- **RX capture:**
  - Trigger: `uart_valid_i`=1 and `uart_rd_o`=0.
  - On trigger, push `uart_rx_data_i` into the RX FIFO (if not full) and set `uart_rd_o`<=1. Otherwise `uart_rd_o`<=0.
  - Gating on `uart_rd_o` prevents a double push while `valid_o` is still high during the acknowledge cycle.
  - If the RX FIFO is full on capture, the byte is discarded, the acknowledge is still issued, and `overrun_o`<=1.
  - A same-cycle host pop does not make room for that byte.
- **Overrun flag:** `overrun_o` stays set until `ovr_clr_i`=1. If a set and a clear happen in the same cycle, set wins.

## Timing

- **TX latency:** from `tx_wr_i` into an empty FIFO with the UART idle, `uart_wr_o` is high 2 cycles later (push edge, then IDLE edge).
- **TX pulse:** `uart_wr_o` is exactly 1 cycle wide. Minimum spacing between successive pulses is 3 cycles; in practice spacing is governed by `busy_o`.
- **RX latency:** `uart_valid_i` rises → byte is in the RX FIFO after 1 edge, and `rx_empty_o` falls in the same cycle. `uart_rd_o` is high for exactly 1 cycle.
- **New byte during acknowledge:** if `uart` latches a new byte on the same edge it samples `rd_i`, `valid_o` stays 1. It is captured 2 cycles after the previous capture; no loss.
- **Show-ahead read:** `rx_data_o` is valid combinationally whenever `rx_empty_o`=0. After a pop, the next entry appears in the following cycle.
- **Mid-operation reset:**
  - Asserting `reset_ni` immediately forces all outputs to reset values and flushes both FIFOs.
  - A frame already being shifted out by `uart` is not affected by this block.
  - Deassertion is synchronised externally; the block is active on the first edge after release.

## Test plan

- **Reset:** hold `reset_ni`=0 with `tx_wr_i`=1 → all outputs at reset values, `tx_count_o`=0. Release, write 0x55 with `uart_busy_i`=0 → `uart_wr_o`=1, `uart_tx_data_o`=0x55 two cycles later, for one cycle.
- **TX burst:** write 0x41,0x42,0x43 back-to-back; model `busy` as high for 20 cycles starting one cycle after each `wr` → three single-cycle `wr` pulses in order, none issued while `busy`=1. `tx_count_o` sequence is 3→2→1→0.
- **TX full:** write TX_DEPTH+2 bytes with `busy` stuck at 1 → `tx_full_o`=1, `tx_count_o`=TX_DEPTH, and the last two bytes never appear on `uart_tx_data_o` after `busy` drops.
- **RX capture:** `uart_valid_i`=1 with data 0xA5, held until the cycle after `uart_rd_o` → exactly one push, `rx_data_o`=0xA5, `rx_count_o`=1, a single `uart_rd_o` pulse. Pop → `rx_empty_o`=1.
- **RX overrun:** deliver RX_DEPTH+1 bytes 0x00..0x10 without popping → `overrun_o`=1, FIFO holds 0x00..0x0F, and 0x10 is acknowledged but dropped. Pulse `ovr_clr_i` together with another overrun → `overrun_o` stays 1.
- **Simultaneous events:** push and pop on the RX FIFO with count=5 in the same cycle → count stays 5 and data order is preserved. Assert reset during TX ISSUE → `uart_wr_o` drops immediately.
